// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB bridge among NREQ requesters.
// Each winning request is latched into command registers, issued to the
// bridge with a single-cycle MTRANS pulse, and completed with a DONE pulse
// once the bridge reports PENABLE && PREADY.
module apb_master_arbiter #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int COMP       = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                           PCLK,
    input  logic                           PRESET,
    input  logic [NREQ-1:0]                REQ,
    input  logic [NREQ-1:0]                REQ_WRITE,
    input  logic [NREQ*COMP-1:0]           REQ_SEL,
    input  logic [NREQ*ADDR_WIDTH-1:0]     REQ_ADDR,
    input  logic [NREQ*(DATA_WIDTH-12)-1:0] REQ_WDATA,
    output logic [NREQ-1:0]                GNT,
    output logic [NREQ-1:0]                DONE,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic                           MTRANS,
    output logic                           MWRITE,
    output logic [COMP-1:0]                MSELx,
    output logic [ADDR_WIDTH-1:0]          MADDR,
    output logic [DATA_WIDTH-13:0]         MWDATA,
    input  logic [DATA_WIDTH-1:0]          MRDATA,
    input  logic                           PENABLE,
    input  logic                           PREADY,
    output logic                           TIMEOUT_ERR
);

    localparam int WD = DATA_WIDTH - 12;
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CPL   = 2'd3;

    logic [1:0]            state;
    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         winner;
    logic                  cmd_write;
    logic [COMP-1:0]       cmd_sel;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [WD-1:0]         cmd_wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [CW-1:0]         wait_cnt;
    logic                  timeout_err;

    // Per-requester views of the flattened request buses.
    logic [COMP-1:0]       sel_arr   [NREQ];
    logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
    logic [WD-1:0]         wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign sel_arr[g]   = REQ_SEL[g*COMP +: COMP];
        assign addr_arr[g]  = REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = REQ_WDATA[g*WD +: WD];
    end

    int unsigned     base;
    int unsigned     pick;
    logic            found;
    logic [NREQ-1:0] rotated;

    // Round-robin search: rotate REQ so the requester after last_grant sits
    // at bit 0, take the first set bit, then map it back to a requester index.
    always_comb begin
        base    = 32'(last_grant) + 32'd1;
        rotated = NREQ'({REQ, REQ} >> base);
        found   = 1'b0;
        pick    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && ((rotated >> k) & NREQ'(1)) != '0) begin
                found = 1'b1;
                pick  = base + k;
                if (pick >= NREQ) begin
                    pick = pick - NREQ;
                end
            end
        end
        winner = IW'(pick);
    end

    // Transaction FSM, command latching, read capture and WAIT timeout tracking.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            last_grant  <= IW'(NREQ - 1);
            cmd_write   <= 1'b0;
            cmd_sel     <= '0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            rdata       <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|REQ) begin
                        cmd_write  <= REQ_WRITE[winner];
                        cmd_sel    <= sel_arr[winner];
                        cmd_addr   <= addr_arr[winner];
                        cmd_wdata  <= wdata_arr[winner];
                        gnt        <= NREQ'(1) << winner;
                        last_grant <= winner;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (PENABLE && PREADY) begin
                        rdata <= MRDATA;
                        state <= ST_CPL;
                    end else if (wait_cnt != CW'(TIMEOUT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                ST_CPL: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign GNT         = gnt;
    assign DONE        = (state == ST_CPL) ? gnt : '0;
    assign MTRANS      = (state == ST_ISSUE);
    assign MWRITE      = cmd_write;
    assign MSELx       = cmd_sel;
    assign MADDR       = cmd_addr;
    assign MWDATA      = cmd_wdata;
    assign RDATA       = rdata;
    assign TIMEOUT_ERR = timeout_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter with a small APB bridge model
// that answers MTRANS with a SETUP cycle and a configurable stalled ACCESS.
module tb_apb_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [1:0]  REQ;
    logic [1:0]  REQ_WRITE;
    logic [7:0]  REQ_SEL;
    logic [63:0] REQ_ADDR;
    logic [39:0] REQ_WDATA;
    logic [1:0]  GNT;
    logic [1:0]  DONE;
    logic [31:0] RDATA;
    logic        MTRANS;
    logic        MWRITE;
    logic [3:0]  MSELx;
    logic [31:0] MADDR;
    logic [19:0] MWDATA;
    logic [31:0] MRDATA;
    logic        PENABLE;
    logic        PREADY;
    logic        TIMEOUT_ERR;

    logic        wr0, wr1;
    logic [3:0]  sel0, sel1;
    logic [31:0] addr0, addr1;
    logic [19:0] wd0, wd1;

    assign REQ_WRITE = {wr1, wr0};
    assign REQ_SEL   = {sel1, sel0};
    assign REQ_ADDR  = {addr1, addr0};
    assign REQ_WDATA = {wd1, wd0};

    apb_master_arbiter #(
        .NREQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .COMP(4), .TIMEOUT(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_SEL(REQ_SEL), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .MTRANS(MTRANS),
        .MWRITE(MWRITE), .MSELx(MSELx), .MADDR(MADDR), .MWDATA(MWDATA),
        .MRDATA(MRDATA), .PENABLE(PENABLE), .PREADY(PREADY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [19:0] wd;
        int unsigned cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(input logic [1:0] d, input logic [31:0] rd, input logic wr,
                               input logic [3:0] sel, input logic [31:0] a,
                               input logic [19:0] w, input int unsigned c);
        exp_t x;
        x.done = d; x.rdata = rd; x.wr = wr; x.sel = sel; x.addr = a; x.wd = w; x.cyc = c;
        sbq.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // Bridge model: SETUP after MTRANS, then ACCESS with stall_cfg PREADY=0 cycles.
    int stall_cfg = 0;
    int ph = 0, nph = 0, rem = 0;
    initial begin
        PENABLE = 1'b0;
        PREADY  = 1'b0;
        forever begin
            @(negedge PCLK);
            if (PRESET) nph = 0;
            else begin
                case (ph)
                    0: nph = MTRANS ? 1 : 0;
                    1: begin nph = 2; rem = stall_cfg; end
                    2: nph = PREADY ? 0 : 2;
                    default: nph = 0;
                endcase
            end
            @(posedge PCLK);
            #1;
            ph = PRESET ? 0 : nph;
            if (ph == 2) begin
                PENABLE = 1'b1;
                if (rem == 0) PREADY = 1'b1;
                else begin
                    PREADY = 1'b0;
                    rem--;
                end
            end else begin
                PENABLE = 1'b0;
                PREADY  = 1'b0;
            end
        end
    end

    // Monitor: every DONE pulse is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge PCLK);
            if (!PRESET && DONE != '0) begin
                if (sbq.size() == 0) chk("done_unexpected", DONE, 0);
                else begin
                    e = sbq.pop_front();
                    chk("done_vec", DONE, e.done);
                    chk("done_cycle", cyc, e.cyc);
                    chk("rdata", RDATA, e.rdata);
                    chk("mwrite", MWRITE, e.wr);
                    chk("msel", MSELx, e.sel);
                    chk("maddr", MADDR, e.addr);
                    chk("mwdata", MWDATA, e.wd);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, GNT, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_mtrans"}, MTRANS, 0);
        chk({tag, "_mwrite"}, MWRITE, 0);
        chk({tag, "_msel"}, MSELx, 0);
        chk({tag, "_maddr"}, MADDR, 0);
        chk({tag, "_mwdata"}, MWDATA, 0);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_timeout"}, TIMEOUT_ERR, 0);
    endtask

    int unsigned t0;

    initial begin
        PRESET = 1'b1;
        REQ = 2'b00;
        wr0 = 0; wr1 = 0; sel0 = 0; sel1 = 0; addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;
        MRDATA = 32'h0;

        // Reset state
        step(3);
        chk_all_zero("reset");
        PRESET = 1'b0;
        step(1);

        // Single write from requester 0
        wr0 = 1; sel0 = 4'b0001; addr0 = 32'h10; wd0 = 20'h5A;
        MRDATA = 32'h1111_1111; stall_cfg = 0; REQ = 2'b01;
        t0 = cyc;
        expect_done(2'b01, 32'h1111_1111, 1, 4'b0001, 32'h10, 20'h5A, t0 + 4);
        step(1);
        chk("w_t1_mtrans", MTRANS, 1);
        chk("w_t1_gnt", GNT, 2'b01);
        step(1);
        chk("w_t2_mtrans", MTRANS, 0);
        step(2);
        chk("w_t4_gnt", GNT, 2'b01);
        REQ = 2'b00;
        step(1);
        chk("w_t5_gnt", GNT, 2'b00);
        step(1);

        // Read by requester 1 with three stalled ACCESS cycles
        wr1 = 0; sel1 = 4'b0100; addr1 = 32'h2000_0008; wd1 = 20'h0;
        MRDATA = 32'hCAFE_F00D; stall_cfg = 3; REQ = 2'b10;
        t0 = cyc;
        expect_done(2'b10, 32'hCAFE_F00D, 0, 4'b0100, 32'h2000_0008, 20'h0, t0 + 7);
        step(7);
        REQ = 2'b00;
        step(1);
        chk("ws_rdata_held", RDATA, 32'hCAFE_F00D);
        chk("ws_no_timeout", TIMEOUT_ERR, 0);
        step(1);

        // Contention: both held, grants alternate starting at 0
        wr0 = 1; sel0 = 4'b0010; addr0 = 32'h100; wd0 = 20'hABCDE;
        wr1 = 0; sel1 = 4'b1000; addr1 = 32'h204; wd1 = 20'h00077;
        MRDATA = 32'h1234_5678; stall_cfg = 0; REQ = 2'b11;
        t0 = cyc;
        expect_done(2'b01, 32'h1234_5678, 1, 4'b0010, 32'h100, 20'hABCDE, t0 + 4);
        expect_done(2'b10, 32'h1234_5678, 0, 4'b1000, 32'h204, 20'h00077, t0 + 9);
        expect_done(2'b01, 32'h1234_5678, 1, 4'b0010, 32'h100, 20'hABCDE, t0 + 14);
        expect_done(2'b10, 32'h1234_5678, 0, 4'b1000, 32'h204, 20'h00077, t0 + 19);
        step(1);
        chk("rr_t1_gnt", GNT, 2'b01);
        step(5);
        chk("rr_t6_gnt", GNT, 2'b10);
        chk("rr_t6_mtrans", MTRANS, 1);
        step(5);
        chk("rr_t11_gnt", GNT, 2'b01);
        step(3);
        REQ = 2'b10;
        step(5);
        REQ = 2'b00;
        step(2);

        // Early drop by requester 1; command registers must not follow REQ inputs
        wr1 = 1; sel1 = 4'b0100; addr1 = 32'h3F0; wd1 = 20'h12345;
        MRDATA = 32'h0BAD_BEEF; REQ = 2'b10;
        t0 = cyc;
        expect_done(2'b10, 32'h0BAD_BEEF, 1, 4'b0100, 32'h3F0, 20'h12345, t0 + 4);
        step(1);
        chk("ed_t1_gnt", GNT, 2'b10);
        step(1);
        REQ = 2'b00; wr1 = 0; sel1 = 4'b0; addr1 = 32'hDEAD_0000; wd1 = 20'h0;
        step(1);
        chk("ed_t3_rdata_hold", RDATA, 32'h1234_5678);
        chk("ed_t3_maddr", MADDR, 32'h3F0);
        step(2);
        chk("ed_t5_gnt", GNT, 2'b00);
        step(1);
        chk("ed_t6_gnt", GNT, 2'b00);
        chk("ed_t6_mtrans", MTRANS, 0);
        step(1);
        chk("ed_t7_gnt", GNT, 2'b00);

        // Timeout: 20 stalled ACCESS cycles, flag after 16 WAIT cycles
        wr0 = 0; sel0 = 4'b0001; addr0 = 32'h40; wd0 = 20'h0;
        MRDATA = 32'h55AA_55AA; stall_cfg = 20; REQ = 2'b01;
        t0 = cyc;
        expect_done(2'b01, 32'h55AA_55AA, 0, 4'b0001, 32'h40, 20'h0, t0 + 24);
        step(17);
        chk("to_t17_flag", TIMEOUT_ERR, 0);
        step(1);
        chk("to_t18_flag", TIMEOUT_ERR, 1);
        step(6);
        REQ = 2'b00;
        step(2);
        chk("to_sticky", TIMEOUT_ERR, 1);

        // Reset during WAIT, then both request: requester 0 first
        wr1 = 1; sel1 = 4'b1000; addr1 = 32'h500; wd1 = 20'hFFFFF;
        stall_cfg = 5; REQ = 2'b10;
        step(3);
        #2;
        PRESET = 1'b1;
        #1;
        chk_all_zero("midrst");
        wr0 = 1; sel0 = 4'b0010; addr0 = 32'h600; wd0 = 20'h0000A;
        REQ = 2'b11; stall_cfg = 0; MRDATA = 32'h7777_7777;
        step(2);
        PRESET = 1'b0;
        t0 = cyc;
        expect_done(2'b01, 32'h7777_7777, 1, 4'b0010, 32'h600, 20'h0000A, t0 + 4);
        expect_done(2'b10, 32'h7777_7777, 1, 4'b1000, 32'h500, 20'hFFFFF, t0 + 9);
        step(1);
        chk("rst_first_gnt", GNT, 2'b01);
        step(3);
        REQ = 2'b10;
        step(5);
        REQ = 2'b00;
        step(3);
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2; number of requesters sharing the APB bridge (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32; address width, equal to the bridge's.
REQ-003 SHALL have parameter DATA_WIDTH, default 32; read width; write data width is DATA_WIDTH-12.
REQ-004 SHALL have parameter COMP, default 4; number of completers (select width).
REQ-005 SHALL have parameter TIMEOUT, default 16; WAIT cycles before the timeout flag is set.
REQ-006 SHALL have port PCLK  in  1  single clock, all state on rising edge.
REQ-007 SHALL have port PRESET  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port REQ  in  NREQ  per-requester transaction request, held until DONE.
REQ-009 SHALL have port REQ_WRITE  in  NREQ  per-requester direction (1 = write).
REQ-010 SHALL have port REQ_SEL  in  NREQ*COMP  flattened per-requester completer select; slice i at [i*COMP +: COMP].
REQ-011 SHALL have port REQ_ADDR  in  NREQ*ADDR_WIDTH  flattened per-requester address.
REQ-012 SHALL have port REQ_WDATA  in  NREQ*(DATA_WIDTH-12)  flattened per-requester write data.
REQ-013 SHALL have port GNT  out  NREQ  one-hot grant.
REQ-014 SHALL have port DONE  out  NREQ  one-hot, one-cycle completion pulse.
REQ-015 SHALL have port RDATA  out  DATA_WIDTH  captured read data, valid with DONE.
REQ-016 SHALL have port MTRANS  out  1  transaction start to the bridge.
REQ-017 SHALL have port MWRITE  out  1  latched direction to the bridge.
REQ-018 SHALL have port MSELx  out  COMP  latched select to the bridge.
REQ-019 SHALL have port MADDR  out  ADDR_WIDTH  latched address to the bridge.
REQ-020 SHALL have port MWDATA  out  DATA_WIDTH-12  latched write data to the bridge.
REQ-021 SHALL have port MRDATA  in  DATA_WIDTH  read data from the bridge.
REQ-022 SHALL have port PENABLE  in  1  bus enable observed from the bridge.
REQ-023 SHALL have port PREADY  in  1  completer ready.
REQ-024 SHALL have port TIMEOUT_ERR  out  1  sticky flag.

Function
REQ-025 SHALL implement an FSM with states IDLE, ISSUE, WAIT and CPL.
REQ-026 IDLE: if any REQ bit is set, SHALL pick the winner, latch its WRITE/SEL/ADDR/WDATA into command registers, set GNT to the winner and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-027 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NREQ; last_grant SHALL update on every grant.
REQ-028 ISSUE: MTRANS SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-029 MTRANS SHALL be 0 in every other state, so the bridge never chains back-to-back transfers.
REQ-030 MWRITE, MSELx, MADDR and MWDATA SHALL be driven from the command registers at all times and SHALL be stable from ISSUE through CPL.
REQ-031 WAIT: on PENABLE && PREADY, SHALL capture MRDATA into RDATA (writes capture as well) and go to CPL.
REQ-032 CPL: DONE SHALL be 1 for one cycle for the winner, GNT SHALL be cleared at the end of the cycle, and the FSM SHALL go to IDLE.
REQ-033 GNT SHALL be held from ISSUE through CPL inclusive.
REQ-034 REQ-to-DONE latency SHALL be 4 cycles with zero wait states, plus 1 cycle per PREADY=0 cycle.
REQ-035 The minimum issue-to-issue spacing SHALL be 5 cycles.
REQ-036 A REQ drop after grant SHALL be ignored; the latched transaction SHALL complete and DONE SHALL still pulse.
REQ-037 REQ changes while granted SHALL NOT alter the command registers.
REQ-038 REQ still high in the cycle after CPL SHALL be re-arbitrated normally; other pending requesters win first.
REQ-039 A WAIT cycle counter SHALL saturate at TIMEOUT.
REQ-040 When the counter reaches TIMEOUT, TIMEOUT_ERR SHALL be set and held until reset.
REQ-041 After a timeout the FSM SHALL keep waiting; there SHALL be no abort.
REQ-042 RDATA SHALL hold its last value until the next capture.

Reset
REQ-043 PRESET=1 SHALL immediately force IDLE, including when asserted mid-transaction.
REQ-044 During reset GNT, DONE, MTRANS, MWRITE, MSELx, MADDR, MWDATA, RDATA, TIMEOUT_ERR and the WAIT counter SHALL be 0.
REQ-045 Reset SHALL set last_grant to NREQ-1, so requester 0 wins the first arbitration.

Verification
REQ-046 Single write: REQ=01, ADDR0=0x10, WDATA0=0x5A, PREADY=1 -> MTRANS 1 cycle at t1, DONE=01 at t4, GNT=01 t1..t4.
REQ-047 Contention: REQ=11 held continuously -> grants alternate 0,1,0,1; each DONE is exactly 5 cycles apart.
REQ-048 Wait states: PREADY=0 for 3 ACCESS cycles, read with MRDATA=0xCAFEF00D -> DONE at t7, RDATA=0xCAFEF00D.
REQ-049 Timeout: PREADY=0 for 20 cycles -> TIMEOUT_ERR=1 after 16 WAIT cycles, DONE after PREADY rises, TIMEOUT_ERR stays 1.
REQ-050 Mid-operation reset: PRESET in WAIT -> all outputs 0 at once; after release REQ=11 -> requester 0 granted first.
REQ-051 Early drop: REQ1 deasserted the cycle after GNT=10 -> transaction completes, DONE=10 pulses, no re-grant.
